// File: rtl/spi_master.sv
// spi_master: mode-3 (CPOL=1, CPHA=1) SPI controller.
// Bytes taken on the out_data valid/ready port are shifted out MSB first on
// SPI_out. SPI_in is captured at the same time, and each received byte is
// presented as a one-cycle in_data_valid pulse.
// Optional feature: define SPI_MASTER_BURST_EN so that the NEXT state also
// accepts a byte, which continues the frame with SPI_not_chip_select held low.
module spi_master #(
    parameter int CLOCK_DIVIDER = 4,
    parameter int CS_SETUP      = 2,
    parameter int CS_IDLE       = 2
) (
    input  logic       clock,
    input  logic       reset,
    output logic       SPI_clock,
    output logic       SPI_out,
    input  logic       SPI_in,
    output logic       SPI_not_chip_select,
    input  logic       out_data_valid,
    input  logic [7:0] out_data,
    output logic       out_data_ready,
    output logic       in_data_valid,
    output logic [7:0] in_data,
    output logic       active
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_LOW,
        S_HIGH,
        S_NEXT,
        S_GAP
    } state_t;

    // The phase counter is loaded with (length - 1) and counts down to zero.
    localparam logic [7:0] DIV_LAST   = 8'(CLOCK_DIVIDER - 1);
    localparam logic [7:0] SETUP_LAST = 8'(CS_SETUP - 1);
    localparam logic [7:0] IDLE_LAST  = 8'(CS_IDLE - 1);

    state_t     state_q, state_d;
    logic [7:0] phase_q, phase_d;
    logic [2:0] bit_q, bit_d;
    logic [7:0] tx_q, tx_d;
    logic [7:0] rx_q, rx_d;
    logic       sclk_q, sclk_d;
    logic       spi_out_q, spi_out_d;
    logic       ncs_q, ncs_d;
    logic       in_valid_q, in_valid_d;
    logic [7:0] in_data_q, in_data_d;
    logic       accept;

    // out_data_ready is decoded directly from the state register.
`ifdef SPI_MASTER_BURST_EN
    assign out_data_ready = (state_q == S_IDLE) || (state_q == S_NEXT);
`else
    assign out_data_ready = (state_q == S_IDLE);
`endif

    assign accept              = out_data_valid && out_data_ready;
    assign SPI_clock           = sclk_q;
    assign SPI_out             = spi_out_q;
    assign SPI_not_chip_select = ncs_q;
    assign active              = ~ncs_q;
    assign in_data_valid       = in_valid_q;
    assign in_data             = in_data_q;

    // Next-state logic: phase sequencing, shifting and output values.
    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        bit_d      = bit_q;
        tx_d       = tx_q;
        rx_d       = rx_q;
        sclk_d     = sclk_q;
        spi_out_d  = spi_out_q;
        ncs_d      = ncs_q;
        in_valid_d = 1'b0;
        in_data_d  = in_data_q;

        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    tx_d      = out_data;
                    bit_d     = 3'd0;
                    phase_d   = SETUP_LAST;
                    ncs_d     = 1'b0;
                    spi_out_d = out_data[7];
                    state_d   = S_SETUP;
                end
            end
            S_SETUP: begin
                if (phase_q == 8'd0) begin
                    sclk_d  = 1'b0;
                    phase_d = DIV_LAST;
                    state_d = S_LOW;
                end else begin
                    phase_d = phase_q - 8'd1;
                end
            end
            S_LOW: begin
                if (phase_q == 8'd0) begin
                    // Sample MISO on the cycle that produces the rising edge.
                    rx_d    = {rx_q[6:0], SPI_in};
                    sclk_d  = 1'b1;
                    phase_d = DIV_LAST;
                    state_d = S_HIGH;
                end else begin
                    phase_d = phase_q - 8'd1;
                end
            end
            S_HIGH: begin
                if (phase_q == 8'd0) begin
                    if (bit_q != 3'd7) begin
                        tx_d      = {tx_q[6:0], 1'b0};
                        spi_out_d = tx_q[6];
                        bit_d     = bit_q + 3'd1;
                        sclk_d    = 1'b0;
                        phase_d   = DIV_LAST;
                        state_d   = S_LOW;
                    end else begin
                        in_data_d  = rx_q;
                        in_valid_d = 1'b1;
                        state_d    = S_NEXT;
                    end
                end else begin
                    phase_d = phase_q - 8'd1;
                end
            end
            S_NEXT: begin
                // accept can only be true here when bursting is enabled.
                if (accept) begin
                    tx_d      = out_data;
                    bit_d     = 3'd0;
                    sclk_d    = 1'b0;
                    spi_out_d = out_data[7];
                    phase_d   = DIV_LAST;
                    state_d   = S_LOW;
                end else begin
                    ncs_d     = 1'b1;
                    spi_out_d = 1'b1;
                    phase_d   = IDLE_LAST;
                    state_d   = S_GAP;
                end
            end
            S_GAP: begin
                if (phase_q == 8'd0) begin
                    state_d = S_IDLE;
                end else begin
                    phase_d = phase_q - 8'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= S_IDLE;
            phase_q    <= 8'd0;
            bit_q      <= 3'd0;
            tx_q       <= 8'd0;
            rx_q       <= 8'd0;
            sclk_q     <= 1'b1;
            spi_out_q  <= 1'b1;
            ncs_q      <= 1'b1;
            in_valid_q <= 1'b0;
            in_data_q  <= 8'd0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            bit_q      <= bit_d;
            tx_q       <= tx_d;
            rx_q       <= rx_d;
            sclk_q     <= sclk_d;
            spi_out_q  <= spi_out_d;
            ncs_q      <= ncs_d;
            in_valid_q <= in_valid_d;
            in_data_q  <= in_data_d;
        end
    end

endmodule
